// File: rtl/dmem_bus_master_pkg.sv
// Shared definitions for the data-memory bus master.
//   state_e                : 2-bit FSM state encoding (IDLE, REQ, WAIT, RESP)
//   TIMEOUT_CYCLES_DEFAULT : default access timeout in cycles spent in REQ+WAIT
package dmem_bus_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

endpackage

// File: rtl/dmem_bus_master_if.sv
// Data-memory bus between the bus master and a memory/interconnect slave.
//   bus_req_o    : request valid (master -> slave)
//   bus_addr_o   : 30-bit word address
//   bus_wdata_o  : lane-aligned write data
//   bus_wen_o    : byte-lane write enables, all zero for a read
//   bus_gnt_i    : slave accepted the request this cycle
//   bus_rvalid_i : response (read data or write ack) valid
//   bus_rdata_i  : response data
//   bus_err_i    : response carries an error, qualified by bus_rvalid_i
interface dmem_bus_master_if;

    logic        bus_req_o;
    logic [29:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_wen_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;
    logic        bus_err_i;

    modport master (
        output bus_req_o, bus_addr_o, bus_wdata_o, bus_wen_o,
        input  bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i
    );

    modport slave (
        input  bus_req_o, bus_addr_o, bus_wdata_o, bus_wen_o,
        output bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i
    );

endinterface

// File: rtl/dmem_timeout_counter.sv
// Saturating access timeout counter.
//   clk_i, rst_n_i : clock, synchronous active-low reset
//   clr_i          : restart counting from zero (has priority over en_i)
//   en_i           : count this cycle
//   expired_o      : this enabled cycle is the TIMEOUT_CYCLES-th counted cycle
//                    (or later); stays high once reached because the count saturates
module dmem_timeout_counter
    import dmem_bus_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The count shows cycles already spent, so the N-th counted cycle sees N-1.
    assign expired_o = en_i && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/dmem_bus_master.sv
// Sequential data-memory bus master: turns a single-cycle load/store slot into
// one registered bus transaction (request/grant, then response), with a timeout,
// and hands the raw read word plus an error flag to the read formatter.
//   clk_i, rst_n_i          : clock, synchronous active-low reset
//   req_valid_i/addr/wdata/wen/ren : memory-stage request slot
//   stall_o                 : hold the memory stage and everything upstream
//   bus                     : master side of the data-memory bus
//   rsp_valid_o/data/err    : response held until rsp_ready_i
module dmem_bus_master
    import dmem_bus_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                req_valid_i,
    input  logic [29:0]         req_addr_i,
    input  logic [31:0]         req_wdata_i,
    input  logic [3:0]          req_wen_i,
    input  logic                req_ren_i,
    output logic                stall_o,
    dmem_bus_master_if.master   bus,
    output logic                rsp_valid_o,
    output logic [31:0]         rsp_data_o,
    output logic                rsp_err_o,
    input  logic                rsp_ready_i
);

    state_e      state_q;
    logic        bus_req_q;
    logic [29:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wen_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_data_q;
    logic        rsp_err_q;

    logic mem_op;
    logic tmo_clr, tmo_en, tmo_expired;

    assign mem_op = req_valid_i & (req_ren_i | (|req_wen_i));

    assign tmo_clr = (state_q == ST_IDLE) & mem_op;
    assign tmo_en  = (state_q == ST_REQ) | (state_q == ST_WAIT);

    dmem_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .clr_i     (tmo_clr),
        .en_i      (tmo_en),
        .expired_o (tmo_expired)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            bus_req_q   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wen_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A nonzero lane mask makes this a write even if ren is also set.
                    if (mem_op) begin
                        addr_q    <= req_addr_i;
                        wdata_q   <= req_wdata_i;
                        wen_q     <= req_wen_i;
                        bus_req_q <= 1'b1;
                        state_q   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Grant beats timeout; an rvalid alongside the grant is dropped.
                    if (bus.bus_gnt_i) begin
                        bus_req_q <= 1'b0;
                        state_q   <= ST_WAIT;
                    end else if (tmo_expired) begin
                        bus_req_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_data_q  <= '0;
                        state_q     <= ST_RESP;
                    end
                end
                ST_WAIT: begin
                    // A response on the timeout cycle still counts as a normal response.
                    if (bus.bus_rvalid_i) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= bus.bus_err_i;
                        rsp_data_q  <= (|wen_q) ? 32'h0 : bus.bus_rdata_i;
                        state_q     <= ST_RESP;
                    end else if (tmo_expired) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_data_q  <= '0;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Accepting cycle must already stall, so this term is combinational on the slot.
    assign stall_o = (state_q == ST_REQ) | (state_q == ST_WAIT) |
                     ((state_q == ST_IDLE) & mem_op);

    assign bus.bus_req_o   = bus_req_q;
    assign bus.bus_addr_o  = addr_q;
    assign bus.bus_wdata_o = wdata_q;
    assign bus.bus_wen_o   = wen_q;

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_dmem_bus_master.sv
module tb_dmem_bus_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [29:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wen;
    logic        req_ren;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        rsp_ready;

    dmem_bus_master_if bus_if ();

    dmem_bus_master #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .req_valid_i (req_valid),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_wen_i   (req_wen),
        .req_ren_i   (req_ren),
        .stall_o     (stall),
        .bus         (bus_if),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .rsp_err_o   (rsp_err),
        .rsp_ready_i (rsp_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_bus_req"}, 32'(bus_if.bus_req_o), 32'h0);
        chk({tag, "_addr"}, 32'(bus_if.bus_addr_o), 32'h0);
        chk({tag, "_wdata"}, bus_if.bus_wdata_o, 32'h0);
        chk({tag, "_wen"}, 32'(bus_if.bus_wen_o), 32'h0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        chk({tag, "_rsp_data"}, rsp_data, 32'h0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'h0);
        chk({tag, "_stall"}, 32'(stall), 32'h0);
    endtask

    // Pop the expected response and compare it to the presented response.
    task automatic sb_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 32'h1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_rsp_data"}, rsp_data, e.data);
            chk({tag, "_rsp_err"}, 32'(rsp_err), 32'(e.err));
        end
    endtask

    // One complete access with a cooperating slave. Called at posedge+1.
    task automatic run_access(input string tag, input logic [29:0] addr,
                              input logic [31:0] wdata, input logic [3:0] wen,
                              input logic ren, input int gnt_dly, input bit rv_with_gnt,
                              input int rsp_dly, input logic [31:0] rdata,
                              input logic err, input int ready_dly);
        exp_t e;
        int   n;
        e.data = (wen != 4'h0) ? 32'h0 : rdata;
        e.err  = err;
        // accept cycle
        req_valid = 1'b1; req_addr = addr; req_wdata = wdata; req_wen = wen; req_ren = ren;
        #1;
        chk({tag, "_c0_stall"}, 32'(stall), 32'h1);
        chk({tag, "_c0_bus_req"}, 32'(bus_if.bus_req_o), 32'h0);
        sb.push_back(e);
        tick();
        req_valid = 1'b0; req_ren = 1'b0; req_wen = 4'h0; req_wdata = 32'h0;
        // request phase, fields must stay stable until the grant
        for (int i = 0; i <= gnt_dly; i++) begin
            if (i == gnt_dly) begin
                bus_if.bus_gnt_i = 1'b1;
                if (rv_with_gnt) begin
                    bus_if.bus_rvalid_i = 1'b1;
                    bus_if.bus_rdata_i  = ~rdata;
                end
            end
            #1;
            chk({tag, "_req"}, 32'(bus_if.bus_req_o), 32'h1);
            chk({tag, "_addr"}, 32'(bus_if.bus_addr_o), 32'(addr));
            chk({tag, "_wen"}, 32'(bus_if.bus_wen_o), 32'(wen));
            chk({tag, "_wdata"}, bus_if.bus_wdata_o, wdata);
            chk({tag, "_req_stall"}, 32'(stall), 32'h1);
            tick();
        end
        bus_if.bus_gnt_i = 1'b0; bus_if.bus_rvalid_i = 1'b0; bus_if.bus_rdata_i = 32'h0;
        // wait phase
        for (int i = 0; i < rsp_dly; i++) begin
            #1;
            chk({tag, "_wait_req"}, 32'(bus_if.bus_req_o), 32'h0);
            chk({tag, "_wait_stall"}, 32'(stall), 32'h1);
            tick();
        end
        bus_if.bus_rvalid_i = 1'b1; bus_if.bus_rdata_i = rdata; bus_if.bus_err_i = err;
        #1;
        chk({tag, "_rv_stall"}, 32'(stall), 32'h1);
        tick();
        bus_if.bus_rvalid_i = 1'b0; bus_if.bus_rdata_i = 32'h0BAD_F00D; bus_if.bus_err_i = 1'b0;
        n = 0;
        while (!rsp_valid && n < 4) begin
            tick();
            n++;
        end
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h1);
        for (int i = 0; i < ready_dly; i++) begin
            #1;
            chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'h1);
            chk({tag, "_hold_stall"}, 32'(stall), 32'h0);
            chk({tag, "_hold_data"}, rsp_data, e.data);
            chk({tag, "_hold_err"}, 32'(rsp_err), 32'(e.err));
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk({tag, "_resp_stall"}, 32'(stall), 32'h0);
        sb_check(tag);
        tick();
        rsp_ready = 1'b0;
        #1;
        chk({tag, "_done_valid"}, 32'(rsp_valid), 32'h0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_wen = '0;
        req_ren = 1'b0; rsp_ready = 1'b0;
        bus_if.bus_gnt_i = 1'b0; bus_if.bus_rvalid_i = 1'b0;
        bus_if.bus_rdata_i = '0; bus_if.bus_err_i = 1'b0;
        tick(); tick();
        #1;
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        tick();

        // minimum-latency read
        run_access("read", 30'h40, 32'h0, 4'h0, 1'b1, 0, 1'b0, 0, 32'hDEAD_BEEF, 1'b0, 0);

        // byte store with a late grant
        run_access("bstore", 30'h123, 32'h00AB_0000, 4'b0100, 1'b0, 5, 1'b0, 0, 32'h5555_AAAA, 1'b0, 0);

        // bus error, response held for 3 cycles
        run_access("buserr", 30'h2000, 32'h0, 4'h0, 1'b1, 1, 1'b0, 1, 32'hCAFE_F00D, 1'b1, 3);

        // rvalid together with grant is dropped, later rvalid is taken
        run_access("gntrv", 30'h3FFF_FFFF, 32'h0, 4'h0, 1'b1, 0, 1'b1, 2, 32'h1234_5678, 1'b0, 1);

        // response on the timeout cycle wins
        run_access("rv_at_tmo", 30'h11, 32'h0, 4'h0, 1'b1, 0, 1'b0, 6, 32'hA5A5_5A5A, 1'b0, 0);

        // grant on the timeout cycle wins
        run_access("gnt_at_tmo", 30'h22, 32'h0, 4'h0, 1'b1, 7, 1'b0, 0, 32'h0F0F_F0F0, 1'b0, 0);

        // non-memory slot: no bus activity, no stall
        req_valid = 1'b1; req_ren = 1'b0; req_wen = 4'h0; req_addr = 30'h77;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("nonmem_stall", 32'(stall), 32'h0);
            tick();
            chk("nonmem_req", 32'(bus_if.bus_req_o), 32'h0);
        end
        req_valid = 1'b0;

        // ren and wen both set: write wins
        run_access("wr_wins", 30'h55, 32'hFEED_FACE, 4'hF, 1'b1, 0, 1'b0, 0, 32'h9999_9999, 1'b0, 0);

        // timeout with no grant at all
        req_valid = 1'b1; req_ren = 1'b1; req_addr = 30'h99;
        #1;
        chk("tmo_c0_stall", 32'(stall), 32'h1);
        sb.push_back('{data: 32'h0, err: 1'b1});
        tick();
        req_valid = 1'b0; req_ren = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("tmo_req", 32'(bus_if.bus_req_o), 32'h1);
            chk("tmo_not_resp", 32'(rsp_valid), 32'h0);
            tick();
        end
        chk("tmo_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("tmo_bus_req_low", 32'(bus_if.bus_req_o), 32'h0);
        chk("tmo_stall_low", 32'(stall), 32'h0);
        rsp_ready = 1'b1;
        #1;
        sb_check("tmo");
        tick();
        rsp_ready = 1'b0;

        // reset while waiting for the response, then a late response
        req_valid = 1'b1; req_ren = 1'b1; req_addr = 30'h1AB;
        tick();
        req_valid = 1'b0; req_ren = 1'b0;
        bus_if.bus_gnt_i = 1'b1;
        tick();
        bus_if.bus_gnt_i = 1'b0;
        #1;
        chk("rst_in_wait_stall", 32'(stall), 32'h1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus_if.bus_rvalid_i = 1'b1; bus_if.bus_rdata_i = 32'h8765_4321;
        #1;
        chk_idle_outputs("rst_mid");
        tick();
        bus_if.bus_rvalid_i = 1'b0; bus_if.bus_rdata_i = 32'h0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_idle_outputs("rst_after");
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
